// File: rtl/rv_mem_stage.sv
// rv_mem_stage: pipeline MEM stage.
//   Drives a req/gnt/rvalid data-memory port, aligns store data onto the byte
//   lanes, extracts and sign/zero-extends load data, stalls the upstream
//   pipeline while an access is outstanding, provides the MEM forwarding value
//   and registers results into MEM/WB.
// Ports:
//   i_mem_clk / i_mem_rst        clock, synchronous active-high reset
//   i_mem_is_load .. _pre_sel    EX/MEM pipeline register contents
//   o_mem_dmem_* / i_mem_dmem_*  data-memory request/response port
//   o_mem_stall                  hold PC, IF/ID, ID/EX and EX/MEM
//   o_mem_misaligned             misaligned access pulse
//   o_mem_rf_wd_fwd              forwarding value to EX
//   o_mem_wb_rf_*                MEM/WB register outputs
module rv_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_mem_clk,
    input  logic            i_mem_rst,
    input  logic            i_mem_is_load,
    input  logic [XLEN-1:0] i_mem_alu_res,
    input  logic [XLEN-1:0] i_mem_ext_imm,
    input  logic [XLEN-1:0] i_mem_pc_plus_4,
    input  logic            i_mem_dmem_we,
    input  logic [XLEN-1:0] i_mem_dmem_wd,
    input  logic [2:0]      i_mem_dmem_bytectrl,
    input  logic            i_mem_rf_we,
    input  logic [4:0]      i_mem_rf_wa,
    input  logic [1:0]      i_mem_rf_wd_pre_sel,
    output logic            o_mem_dmem_req,
    output logic            o_mem_dmem_we,
    output logic [XLEN-1:0] o_mem_dmem_addr,
    output logic [3:0]      o_mem_dmem_be,
    output logic [XLEN-1:0] o_mem_dmem_wd,
    input  logic            i_mem_dmem_gnt,
    input  logic            i_mem_dmem_rvalid,
    input  logic [XLEN-1:0] i_mem_dmem_rdata,
    output logic            o_mem_stall,
    output logic            o_mem_misaligned,
    output logic [XLEN-1:0] o_mem_rf_wd_fwd,
    output logic            o_mem_wb_rf_we,
    output logic [4:0]      o_mem_wb_rf_wa,
    output logic [XLEN-1:0] o_mem_wb_rf_wd
);

    typedef enum logic {IDLE, WAIT_RSP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [4:0]      wa_q, wa_d;
    logic            rf_we_q, rf_we_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_wa_q, wb_wa_d;
    logic [XLEN-1:0] wb_wd_q, wb_wd_d;

    logic            access, is_half, is_word, mis_cond, idle;
    logic [XLEN-1:0] load_data;

    function automatic logic [XLEN-1:0] sel_wd(input logic [1:0] sel,
                                               input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] ld,
                                               input logic [XLEN-1:0] pc4,
                                               input logic [XLEN-1:0] imm);
        case (sel)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return pc4;
            default: return imm;
        endcase
    endfunction

    // The addressed byte/half is shifted down to bit 0, then extended.
    function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] rdata,
                                                     input logic [1:0] off,
                                                     input logic [2:0] ctrl);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (ctrl)
            3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        access   = i_mem_is_load | i_mem_dmem_we;
        is_half  = (i_mem_dmem_bytectrl[1:0] == 2'b01);
        is_word  = i_mem_dmem_bytectrl[1];
        mis_cond = (is_half & i_mem_alu_res[0]) | (is_word & (|i_mem_alu_res[1:0]));
        idle     = (state_q == IDLE);

        // In WAIT_RSP the request has already been accepted, so req is low.
        o_mem_dmem_req   = idle & access & ~mis_cond;
        o_mem_misaligned = idle & access & mis_cond;
        o_mem_dmem_we    = i_mem_dmem_we;
        o_mem_dmem_addr  = {i_mem_alu_res[XLEN-1:2], 2'b00};

        case (i_mem_dmem_bytectrl[1:0])
            2'b00: begin
                o_mem_dmem_be = 4'b0001 << i_mem_alu_res[1:0];
                o_mem_dmem_wd = {4{i_mem_dmem_wd[7:0]}};
            end
            2'b01: begin
                o_mem_dmem_be = 4'b0011 << i_mem_alu_res[1:0];
                o_mem_dmem_wd = {2{i_mem_dmem_wd[15:0]}};
            end
            default: begin
                o_mem_dmem_be = 4'b1111;
                o_mem_dmem_wd = i_mem_dmem_wd;
            end
        endcase

        // A granted load still stalls: its data only arrives with rvalid.
        if (idle) o_mem_stall = o_mem_dmem_req & (~i_mem_dmem_gnt | i_mem_is_load);
        else      o_mem_stall = ~i_mem_dmem_rvalid;

        o_mem_rf_wd_fwd = sel_wd(i_mem_rf_wd_pre_sel, i_mem_alu_res, i_mem_alu_res,
                                 i_mem_pc_plus_4, i_mem_ext_imm);
        load_data = extract_load(i_mem_dmem_rdata, off_q, ctrl_q);

        state_d = state_q;
        off_d   = off_q;
        ctrl_d  = ctrl_q;
        wa_d    = wa_q;
        rf_we_d = rf_we_q;
        wb_we_d = wb_we_q;
        wb_wa_d = wb_wa_q;
        wb_wd_d = wb_wd_q;

        if (o_mem_stall) begin
            wb_we_d = 1'b0;
        end else if (!idle) begin
            // Load completion: rvalid seen in WAIT_RSP.
            wb_we_d = rf_we_q;
            wb_wa_d = wa_q;
            wb_wd_d = sel_wd(i_mem_rf_wd_pre_sel, i_mem_alu_res, load_data,
                             i_mem_pc_plus_4, i_mem_ext_imm);
            state_d = IDLE;
        end else begin
            wb_we_d = i_mem_rf_we & ~o_mem_misaligned;
            wb_wa_d = i_mem_rf_wa;
            wb_wd_d = o_mem_rf_wd_fwd;
        end

        if (idle && o_mem_dmem_req && i_mem_dmem_gnt && i_mem_is_load) begin
            state_d = WAIT_RSP;
            off_d   = i_mem_alu_res[1:0];
            ctrl_d  = i_mem_dmem_bytectrl;
            wa_d    = i_mem_rf_wa;
            rf_we_d = i_mem_rf_we;
        end
    end

    always_ff @(posedge i_mem_clk) begin
        if (i_mem_rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            ctrl_q  <= '0;
            wa_q    <= '0;
            rf_we_q <= 1'b0;
            wb_we_q <= 1'b0;
            wb_wa_q <= '0;
            wb_wd_q <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            ctrl_q  <= ctrl_d;
            wa_q    <= wa_d;
            rf_we_q <= rf_we_d;
            wb_we_q <= wb_we_d;
            wb_wa_q <= wb_wa_d;
            wb_wd_q <= wb_wd_d;
        end
    end

    assign o_mem_wb_rf_we = wb_we_q;
    assign o_mem_wb_rf_wa = wb_wa_q;
    assign o_mem_wb_rf_wd = wb_wd_q;

endmodule

// File: tb/tb_rv_mem_stage.sv
module tb_rv_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_load, dmem_we, rf_we, gnt, rvalid;
    logic [31:0] alu_res, ext_imm, pc4, wd_in, rdata;
    logic [2:0]  bytectrl;
    logic [4:0]  rf_wa;
    logic [1:0]  pre_sel;
    logic        req, o_we, stall, mis, wb_we;
    logic [31:0] addr, o_wd, fwd, wb_wd;
    logic [3:0]  be;
    logic [4:0]  wb_wa;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_mem_stage #(.XLEN(32)) dut (
        .i_mem_clk(clk), .i_mem_rst(rst), .i_mem_is_load(is_load),
        .i_mem_alu_res(alu_res), .i_mem_ext_imm(ext_imm), .i_mem_pc_plus_4(pc4),
        .i_mem_dmem_we(dmem_we), .i_mem_dmem_wd(wd_in), .i_mem_dmem_bytectrl(bytectrl),
        .i_mem_rf_we(rf_we), .i_mem_rf_wa(rf_wa), .i_mem_rf_wd_pre_sel(pre_sel),
        .o_mem_dmem_req(req), .o_mem_dmem_we(o_we), .o_mem_dmem_addr(addr),
        .o_mem_dmem_be(be), .o_mem_dmem_wd(o_wd), .i_mem_dmem_gnt(gnt),
        .i_mem_dmem_rvalid(rvalid), .i_mem_dmem_rdata(rdata), .o_mem_stall(stall),
        .o_mem_misaligned(mis), .o_mem_rf_wd_fwd(fwd), .o_mem_wb_rf_we(wb_we),
        .o_mem_wb_rf_wa(wb_wa), .o_mem_wb_rf_wd(wb_wd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] bc);
        if (bc[1:0] == 2'b00) return 1;
        if (bc[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] bc, input logic [31:0] a);
        return (a % m_size(bc)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] bc, input logic [31:0] a);
        int s;
        int v;
        s = m_size(bc);
        v = 0;
        for (int k = 0; k < s; k++) v += 2 ** ((a % 4) + k);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] bc, input logic [31:0] d);
        if (m_size(bc) == 1) return (d & 32'hFF) * 32'h01010101;
        if (m_size(bc) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] bc, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v, span;
        span = longint'(1) << (8 * m_size(bc));
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (bc[2] == 1'b0 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sel, input logic [31:0] a,
                                         input logic [31:0] ld, input logic [31:0] p,
                                         input logic [31:0] imm);
        case (sel)
            2'b00:   return a;
            2'b01:   return ld;
            2'b10:   return p;
            default: return imm;
        endcase
    endfunction

    // Runs one instruction; entered and left at posedge+1.
    task automatic do_instr(input logic ld, input logic st, input logic [2:0] bc,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] imm, input logic [31:0] p,
                            input logic rwe, input logic [4:0] wa, input logic [1:0] sel,
                            input int gdly, input int rdly, input logic [31:0] rsp);
        logic acc, mi, es;
        is_load = ld; dmem_we = st; bytectrl = bc; alu_res = a; wd_in = d;
        ext_imm = imm; pc4 = p; rf_we = rwe; rf_wa = wa; pre_sel = sel;
        gnt = 1'b0; rvalid = 1'b0;
        acc = ld | st;
        mi = acc && m_mis(bc, a);
        if (!acc || mi) begin
            #3;
            check_eq("req_noacc", {31'b0, req}, 32'd0);
            check_eq("stall_noacc", {31'b0, stall}, 32'd0);
            check_eq("misaligned", {31'b0, mis}, {31'b0, mi});
            check_eq("fwd", fwd, m_wd(sel, a, a, p, imm));
            @(posedge clk); #1;
            check_eq("wb_we", {31'b0, wb_we}, {31'b0, rwe & ~mi});
            if (rwe && !mi) begin
                check_eq("wb_wa", {27'b0, wb_wa}, {27'b0, wa});
                check_eq("wb_wd", wb_wd, m_wd(sel, a, a, p, imm));
            end
        end else begin
            for (int g = 0; g <= gdly; g++) begin
                gnt = (g == gdly);
                es = (g < gdly) || ld;
                #3;
                check_eq("req", {31'b0, req}, 32'd1);
                check_eq("addr", addr, a & 32'hFFFFFFFC);
                check_eq("be", {28'b0, be}, m_be(bc, a));
                check_eq("dmem_we", {31'b0, o_we}, {31'b0, st});
                if (st) check_eq("store_wd", o_wd, m_store(bc, d));
                check_eq("stall_req", {31'b0, stall}, {31'b0, es});
                @(posedge clk); #1;
                if (es) check_eq("wb_we_bubble", {31'b0, wb_we}, 32'd0);
            end
            gnt = 1'b0;
            if (st) check_eq("wb_we_store", {31'b0, wb_we}, {31'b0, rwe});
            if (ld) begin
                for (int w = 0; w <= rdly; w++) begin
                    rvalid = (w == rdly);
                    rdata = rvalid ? rsp : $urandom;
                    #3;
                    check_eq("req_wait", {31'b0, req}, 32'd0);
                    check_eq("stall_wait", {31'b0, stall}, {31'b0, w != rdly});
                    @(posedge clk); #1;
                    rvalid = 1'b0;
                    if (w != rdly) begin
                        check_eq("wb_we_wait", {31'b0, wb_we}, 32'd0);
                    end else begin
                        check_eq("wb_we_load", {31'b0, wb_we}, {31'b0, rwe});
                        check_eq("wb_wa_load", {27'b0, wb_wa}, {27'b0, wa});
                        check_eq("wb_wd_load", wb_wd, m_wd(sel, a, m_load(bc, a, rsp), p, imm));
                    end
                end
            end
        end
    endtask

    task automatic zero_inputs();
        is_load = 0; dmem_we = 0; rf_we = 0; gnt = 0; rvalid = 0;
        alu_res = 0; ext_imm = 0; pc4 = 0; wd_in = 0; rdata = 0;
        bytectrl = 0; rf_wa = 0; pre_sel = 0;
    endtask

    initial begin
        logic [2:0] bcs [5];
        int kind;
        logic [2:0] bc;
        bcs[0] = 3'b000; bcs[1] = 3'b001; bcs[2] = 3'b010; bcs[3] = 3'b100; bcs[4] = 3'b101;

        zero_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        alu_res = 32'h0000_0055;
        #2;
        check_eq("rst_wb_we", {31'b0, wb_we}, 32'd0);
        check_eq("rst_wb_wa", {27'b0, wb_wa}, 32'd0);
        check_eq("rst_wb_wd", wb_wd, 32'd0);
        check_eq("rst_req", {31'b0, req}, 32'd0);
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_mis", {31'b0, mis}, 32'd0);
        check_eq("rst_fwd", fwd, 32'h55);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        do_instr(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0, 5'd0, 2'b00, 0, 0, 0);
        do_instr(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 5'd0, 2'b00, 2, 0, 0);
        do_instr(1, 0, 3'b000, 32'h201, 0, 0, 0, 1, 5'd7, 2'b01, 0, 3, 32'h00008000);
        check_eq("lb_value", wb_wd, 32'hFFFFFF80);
        do_instr(1, 0, 3'b100, 32'h201, 0, 0, 0, 1, 5'd8, 2'b01, 0, 3, 32'h00008000);
        check_eq("lbu_value", wb_wd, 32'h00000080);
        do_instr(1, 0, 3'b101, 32'h202, 0, 0, 0, 1, 5'd9, 2'b01, 1, 1, 32'hBEEF1234);
        check_eq("lhu_value", wb_wd, 32'h0000BEEF);
        do_instr(1, 0, 3'b001, 32'h201, 0, 0, 0, 1, 5'd10, 2'b01, 0, 0, 0);
        do_instr(0, 0, 3'b000, 32'h40, 0, 0, 32'h1008, 1, 5'd1, 2'b10, 0, 0, 0);
        check_eq("jal_value", wb_wd, 32'h1008);
        do_instr(0, 0, 3'b000, 32'h40, 0, 32'h12345000, 0, 1, 5'd2, 2'b11, 0, 0, 0);
        check_eq("lui_value", wb_wd, 32'h12345000);

        // Reset while waiting for a load response
        is_load = 1; bytectrl = 3'b010; alu_res = 32'h300; rf_we = 1; rf_wa = 5'd12;
        pre_sel = 2'b01; gnt = 1;
        @(posedge clk); #1;
        zero_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        #2;
        check_eq("rstw_stall", {31'b0, stall}, 32'd0);
        check_eq("rstw_req", {31'b0, req}, 32'd0);
        check_eq("rstw_wb_we0", {31'b0, wb_we}, 32'd0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        check_eq("rstw_wb_we", {31'b0, wb_we}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                bc = bcs[$urandom_range(0, 4)];
                do_instr(1, 0, bc, $urandom, 0, $urandom, $urandom, 1, 5'($urandom),
                         2'b01, $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
            end else if (kind == 2) begin
                bc = bcs[$urandom_range(0, 2)];
                do_instr(0, 1, bc, $urandom, $urandom, $urandom, $urandom, 0, 5'($urandom),
                         2'b00, $urandom_range(0, 2), 0, 0);
            end else begin
                do_instr(0, 0, 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                         1'($urandom), 5'($urandom), 2'($urandom), 0, 0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
